// File: rtl/sr_writer_pkg.sv
// Shared types and defaults for the SR bank writer.
package sr_writer_pkg;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_RETRY = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;
endpackage

// File: rtl/sr_excite.sv
// Single-bit SR excitation: set on 0->1, reset on 1->0, 00 on hold; never 11.
module sr_excite (
    input  logic target,
    input  logic q,
    output logic s,
    output logic r
);
    assign s = target & ~q;
    assign r = ~target & q;
endmodule

// File: rtl/sr_bank_writer.sv
// Drives a bank of SR flip-flops toward a requested value, verifying the
// result and re-driving up to MAX_RETRY times before flagging an error.
module sr_bank_writer
    import sr_writer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err
);
    // Keep at least one bit so MAX_RETRY=0 still elaborates.
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] target;
    logic [RW-1:0]    retry;
    logic [WIDTH-1:0] s_ex, r_ex;
    logic             match, retry_max;

    assign match     = (q_fb == target);
    assign retry_max = (retry == RW'(MAX_RETRY));

    for (genvar g = 0; g < WIDTH; g++) begin : g_ex
        sr_excite u_ex (
            .target(target[g]),
            .q     (q_fb[g]),
            .s     (s_ex[g]),
            .r     (r_ex[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            target <= '0;
            retry  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                target <= req_data;
                retry  <= '0;
            end else if (state == CHECK && !match && !retry_max) begin
                retry <= retry + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        S         = '0;
        R         = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = DRIVE;
            end
            DRIVE: begin
                S         = s_ex;
                R         = r_ex;
                state_nxt = SETTLE;
            end
            SETTLE: state_nxt = CHECK;
            CHECK: begin
                if (match) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (!retry_max) begin
                    state_nxt = DRIVE;
                end else begin
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sr_bank_writer.sv
// Directed bench: SR bank model on the same clock, per-cycle output vectors.
module tb_sr_bank_writer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, req_valid, req_ready, done, err;
    logic [W-1:0] req_data, S, R, bank, stuck0, load_val;
    logic         load;

    int total = 0, bad = 0;
    int acc_cnt = 0, done_cnt = 0, err_cnt = 0;

    always #5 clk = ~clk;

    sr_bank_writer #(.WIDTH(W), .MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .S(S), .R(R), .q_fb(bank), .done(done), .err(err)
    );

    // Bank of SR flip-flops; stuck0 bits never leave 0.
    always @(posedge clk) begin
        logic [W-1:0] nq;
        if (rst) nq = '0;
        else if (load) nq = load_val;
        else begin
            nq = bank;
            for (int i = 0; i < W; i++) begin
                if (S[i]) nq[i] = 1'b1;
                else if (R[i]) nq[i] = 1'b0;
            end
        end
        bank <= nq & ~stuck0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change #1 after posedge, so the negedge monitor sees them stable.
    always @(negedge clk) begin
        chk("s_and_r", 32'(S & R), 32'd0);
        chk("done_and_err", 32'(done & err), 32'd0);
        if (req_valid && req_ready && !rst) acc_cnt++;
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    function automatic logic [31:0] vec(logic rdy, logic d, logic e, logic [W-1:0] s, logic [W-1:0] r);
        return 32'({rdy, d, e, s, r});
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [W-1:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    // One write: cycle c after acceptance is DRIVE/SETTLE/CHECK by (c-1)%3.
    task automatic do_write(input string tag, input logic [W-1:0] d, input logic [W-1:0] es,
                            input logic [W-1:0] er, input bit exp_done, input int lat);
        logic dx, ex, drv;
        req_valid = 1'b1; req_data = d;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            drv = ((c - 1) % 3 == 0);
            dx  = (c == lat) && exp_done;
            ex  = (c == lat) && !exp_done;
            chk({tag, "_cyc"}, vec(req_ready, done, err, S, R),
                vec(1'b0, dx, ex, drv ? es : '0, drv ? er : '0));
            step();
        end
        @(negedge clk);
        chk({tag, "_idle"}, vec(req_ready, done, err, S, R), vec(1'b1, 1'b0, 1'b0, '0, '0));
        step();
    endtask

    initial begin
        int dc, ec;
        rst = 1'b1; req_valid = 1'b0; req_data = '0; load = 1'b0; load_val = '0; stuck0 = '0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", vec(req_ready, done, err, S, R), vec(1'b1, 1'b0, 1'b0, '0, '0));
        step();

        preload(8'h00);
        do_write("set", 8'hA5, 8'hA5, 8'h00, 1'b1, 3);
        chk("set_bank", 32'(bank), 32'hA5);

        preload(8'hFF);
        do_write("clr", 8'h0F, 8'h00, 8'hF0, 1'b1, 3);
        chk("clr_bank", 32'(bank), 32'h0F);

        preload(8'h3C);
        do_write("same", 8'h3C, 8'h00, 8'h00, 1'b1, 3);

        stuck0 = 8'h01;
        preload(8'h00);
        dc = done_cnt;
        do_write("stuck", 8'h01, 8'h01, 8'h00, 1'b0, 9);
        chk("stuck_no_done", 32'(done_cnt), 32'(dc));
        stuck0 = 8'h00;

        // Reset during SETTLE aborts silently.
        preload(8'h00);
        dc = done_cnt; ec = err_cnt;
        req_valid = 1'b1; req_data = 8'h5A;
        step();
        req_valid = 1'b0;
        step();
        @(negedge clk);
        chk("rst_in_settle_s", 32'(S), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after", vec(req_ready, done, err, S, R), vec(1'b1, 1'b0, 1'b0, '0, '0));
        for (int i = 0; i < 4; i++) step();
        chk("rst_no_done", 32'(done_cnt), 32'(dc));
        chk("rst_no_err", 32'(err_cnt), 32'(ec));

        // Busy: req_valid held across a whole write.
        preload(8'h00);
        acc_cnt = 0;
        req_valid = 1'b1; req_data = 8'h11;
        step();                                   // accepted, DRIVE next
        @(negedge clk);
        chk("busy_drive", vec(req_ready, done, err, S, R), vec(1'b0, 1'b0, 1'b0, 8'h11, 8'h00));
        step(); step();                           // SETTLE, CHECK
        req_data = 8'h33;
        @(negedge clk);
        chk("busy_check", vec(req_ready, done, err, S, R), vec(1'b0, 1'b1, 1'b0, '0, '0));
        chk("busy_acc1", 32'(acc_cnt), 32'd1);
        step();                                   // IDLE with valid high
        @(negedge clk);
        chk("busy_idle_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("busy_drive2", vec(req_ready, done, err, S, R), vec(1'b0, 1'b0, 1'b0, 8'h22, 8'h00));
        step(); step();
        @(negedge clk);
        chk("busy_done2", 32'(done), 32'd1);
        chk("busy_acc2", 32'(acc_cnt), 32'd2);
        step();
        chk("busy_bank", 32'(bank), 32'h33);
        chk("err_total", 32'(err_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end
endmodule
